// File: rtl/p3_execute.sv
// Execute stage of the p3 datapath: ALU, shifter, immediates and I/O.
// Results, flags and writeback controls register on the falling clock edge.
module p3_execute (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  state,
    input  logic [15:0] ir,
    input  logic [15:0] ar,
    input  logic [15:0] br,
    input  logic [15:0] ext_in,
    output logic [15:0] dr,
    output logic        op_reg_write,
    output logic [2:0]  address_for_write,
    output logic        flag_s,
    output logic        flag_z,
    output logic        flag_c,
    output logic        flag_v,
    output logic [15:0] out_data,
    output logic        halt
);

    localparam logic [2:0] EXEC = 3'b011;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SLR = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;
    localparam logic [3:0] OP_IN  = 4'b1100;
    localparam logic [3:0] OP_OUT = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic [15:0] dr_q, dr_d;
    logic [15:0] out_q, out_d;
    logic        wr_q, wr_d;
    logic [2:0]  addr_q, addr_d;
    logic        s_q, s_d;
    logic        z_q, z_d;
    logic        c_q, c_d;
    logic        v_q, v_d;
    logic        halt_q, halt_d;

    logic [3:0]  op;
    logic [3:0]  sh;
    logic [4:0]  rsh;
    logic [15:0] sext;
    logic [16:0] sum;
    logic [16:0] diff;
    logic [16:0] shl;
    logic [16:0] shr;
    logic [16:0] sra;
    logic [15:0] rot;

    logic [15:0] alu_r;
    logic        alu_c;
    logic        alu_v;
    logic        alu_fl;
    logic        alu_wr;

    logic        is_alu;
    logic        is_imm;

    assign op     = ir[7:4];
    assign sh     = ir[3:0];
    assign rsh    = 5'd16 - {1'b0, sh};
    assign sext   = {{8{ir[7]}}, ir[7:0]};
    assign is_alu = (ir[15:14] == 2'b11);
    assign is_imm = (ir[15:14] == 2'b10);

    // Extra bit on each side captures the carry/borrow or the last bit shifted out.
    assign sum  = {1'b0, br} + {1'b0, ar};
    assign diff = {1'b0, br} - {1'b0, ar};
    assign shl  = {1'b0, br} << sh;
    assign shr  = {br, 1'b0} >> sh;
    assign sra  = $signed({br, 1'b0}) >>> sh;
    assign rot  = (br << sh) | (br >> rsh);

    always_comb begin
        alu_r  = br;
        alu_c  = 1'b0;
        alu_v  = 1'b0;
        alu_fl = 1'b1;
        alu_wr = 1'b1;
        case (op)
            OP_ADD: begin
                alu_r = sum[15:0];
                alu_c = sum[16];
                alu_v = (br[15] == ar[15]) && (sum[15] != br[15]);
            end
            OP_SUB, OP_CMP: begin
                alu_r  = diff[15:0];
                alu_c  = diff[16];
                alu_v  = (br[15] != ar[15]) && (diff[15] != br[15]);
                alu_wr = (op == OP_SUB);
            end
            OP_AND: alu_r = br & ar;
            OP_OR:  alu_r = br | ar;
            OP_XOR: alu_r = br ^ ar;
            OP_MOV: alu_r = ar;
            OP_SLL: begin
                alu_r = shl[15:0];
                alu_c = shl[16];
            end
            OP_SLR: begin
                alu_r = rot;
                alu_c = (sh != 4'd0) && rot[0];
            end
            OP_SRL: begin
                alu_r = shr[16:1];
                alu_c = shr[0];
            end
            OP_SRA: begin
                alu_r = sra[16:1];
                alu_c = sra[0];
            end
            default: begin
                alu_fl = 1'b0;
                alu_wr = 1'b0;
            end
        endcase
    end

    always_comb begin
        dr_d   = dr_q;
        out_d  = out_q;
        wr_d   = wr_q;
        addr_d = addr_q;
        s_d    = s_q;
        z_d    = z_q;
        c_d    = c_q;
        v_d    = v_q;
        halt_d = halt_q;
        if (state == EXEC && !halt_q) begin
            addr_d = ir[10:8];
            wr_d   = 1'b0;
            unique case (1'b1)
                is_alu: begin
                    wr_d = alu_wr;
                    if (alu_fl) begin
                        dr_d = alu_r;
                        s_d  = alu_r[15];
                        z_d  = (alu_r == 16'h0000);
                        c_d  = alu_c;
                        v_d  = alu_v;
                    end
                    if (op == OP_IN) begin
                        dr_d = ext_in;
                        wr_d = 1'b1;
                    end
                    if (op == OP_OUT) out_d = ar;
                    if (op == OP_HLT) halt_d = 1'b1;
                end
                is_imm: begin
                    dr_d = sext;
                    wr_d = (ir[13:11] == 3'b000);
                end
                default: dr_d = ar + sext;
            endcase
        end
    end

    always_ff @(negedge clock) begin
        if (!reset) begin
            dr_q   <= 16'h0000;
            out_q  <= 16'h0000;
            wr_q   <= 1'b0;
            addr_q <= 3'd0;
            s_q    <= 1'b0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            dr_q   <= dr_d;
            out_q  <= out_d;
            wr_q   <= wr_d;
            addr_q <= addr_d;
            s_q    <= s_d;
            z_q    <= z_d;
            c_q    <= c_d;
            v_q    <= v_d;
            halt_q <= halt_d;
        end
    end

    assign dr                = dr_q;
    assign out_data          = out_q;
    assign op_reg_write      = wr_q;
    assign address_for_write = addr_q;
    assign flag_s            = s_q;
    assign flag_z            = z_q;
    assign flag_c            = c_q;
    assign flag_v            = v_q;
    assign halt              = halt_q;

endmodule

// File: tb/tb_p3_execute.sv
// Scoreboard bench for p3_execute: driver pushes model expectations,
// a monitor compares them after every falling edge.
module tb_p3_execute;

    typedef struct packed {
        logic [15:0] dr;
        logic        w;
        logic [2:0]  a;
        logic        s;
        logic        z;
        logic        c;
        logic        v;
        logic [15:0] od;
        logic        h;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [2:0]  state;
    logic [15:0] ir;
    logic [15:0] ar;
    logic [15:0] br;
    logic [15:0] ext_in;
    logic [15:0] dr;
    logic        op_reg_write;
    logic [2:0]  address_for_write;
    logic        flag_s;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;
    logic [15:0] out_data;
    logic        halt;

    exp_t q[$];
    exp_t m;
    int   total;
    int   bad;

    p3_execute dut (
        .clock(clock),
        .reset(reset),
        .state(state),
        .ir(ir),
        .ar(ar),
        .br(br),
        .ext_in(ext_in),
        .dr(dr),
        .op_reg_write(op_reg_write),
        .address_for_write(address_for_write),
        .flag_s(flag_s),
        .flag_z(flag_z),
        .flag_c(flag_c),
        .flag_v(flag_v),
        .out_data(out_data),
        .halt(halt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference behaviour written from the instruction-set rules with int arithmetic.
    function automatic exp_t model(exp_t p, bit rst, logic [2:0] st,
                                   logic [15:0] i, logic [15:0] av,
                                   logic [15:0] bv, logic [15:0] ev);
        exp_t n;
        int   b, a, sb, sa, r, sh, t;
        bit   fl;
        n = p;
        if (!rst) return '0;
        if (st != 3'b011 || p.h) return p;
        n.a = i[10:8];
        n.w = 1'b0;
        b   = int'(bv);
        a   = int'(av);
        sb  = int'($signed(bv));
        sa  = int'($signed(av));
        sh  = int'(i[3:0]);
        r   = 0;
        fl  = 1'b1;
        if (i[15:14] == 2'b11) begin
            n.c = 1'b0;
            n.v = 1'b0;
            case (int'(i[7:4]))
                0: begin
                    r = b + a; t = sb + sa;
                    n.c = r > 65535;
                    n.v = (t > 32767) || (t < -32768);
                    n.w = 1'b1;
                end
                1, 5: begin
                    r = b - a; t = sb - sa;
                    n.c = b < a;
                    n.v = (t > 32767) || (t < -32768);
                    n.w = (i[7:4] == 4'd1);
                end
                2: begin r = b & a; n.w = 1'b1; end
                3: begin r = b | a; n.w = 1'b1; end
                4: begin r = b ^ a; n.w = 1'b1; end
                6: begin r = a; n.w = 1'b1; end
                8: begin
                    r = b << sh;
                    if (sh != 0) n.c = ((b >> (16 - sh)) & 1) != 0;
                    n.w = 1'b1;
                end
                9: begin
                    r = (sh == 0) ? b : ((b << sh) | (b >> (16 - sh)));
                    if (sh != 0) n.c = (r & 1) != 0;
                    n.w = 1'b1;
                end
                10, 11: begin
                    r = (i[7:4] == 4'd10) ? (b >> sh) : (sb >>> sh);
                    if (sh != 0) n.c = ((b >> (sh - 1)) & 1) != 0;
                    n.w = 1'b1;
                end
                12: begin fl = 1'b0; n.dr = ev; n.w = 1'b1; end
                13: begin fl = 1'b0; n.od = av; end
                15: begin fl = 1'b0; n.h = 1'b1; end
                default: fl = 1'b0;
            endcase
            if (fl) begin
                n.dr = r[15:0];
                n.s  = n.dr[15];
                n.z  = (n.dr == 16'h0000);
            end else begin
                n.c = p.c;
                n.v = p.v;
            end
        end else if (i[15:14] == 2'b10) begin
            n.dr = {{8{i[7]}}, i[7:0]};
            n.w  = (i[15:11] == 5'b10000);
        end else begin
            t    = a + int'($signed(i[7:0]));
            n.dr = t[15:0];
        end
        return n;
    endfunction

    task automatic drive(bit rst, logic [2:0] st, logic [15:0] i,
                         logic [15:0] av, logic [15:0] bv, logic [15:0] ev);
        @(posedge clock);
        reset  = rst;
        state  = st;
        ir     = i;
        ar     = av;
        br     = bv;
        ext_in = ev;
        m = model(m, rst, st, i, av, bv, ev);
        q.push_back(m);
    endtask

    // Replace the newest expectation with hand-written values from the ISA examples.
    task automatic gold(exp_t e);
        void'(q.pop_back());
        q.push_back(e);
        m = e;
    endtask

    initial begin : monitor
        exp_t e;
        exp_t g;
        forever begin
            @(negedge clock);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                g = '{dr, op_reg_write, address_for_write, flag_s, flag_z,
                      flag_c, flag_v, out_data, halt};
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got dr=%h w=%b a=%0d szcv=%b%b%b%b od=%h h=%b want dr=%h w=%b a=%0d szcv=%b%b%b%b od=%h h=%b",
                             $time, g.dr, g.w, g.a, g.s, g.z, g.c, g.v, g.od, g.h,
                             e.dr, e.w, e.a, e.s, e.z, e.c, e.v, e.od, e.h);
                end
            end
        end
    end

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin : driver
        exp_t e;
        logic [15:0] ri;
        logic [3:0]  rop;
        bit          rr;
        logic [2:0]  rs;
        total  = 0;
        bad    = 0;
        m      = '0;
        reset  = 1'b0;
        state  = 3'b000;
        ir     = 16'h0000;
        ar     = 16'h0000;
        br     = 16'h0000;
        ext_in = 16'h0000;

        drive(0, 3'b011, 16'hC100, 16'h0001, 16'h7FFF, 16'h1234);
        drive(0, 3'b000, 16'hC100, 16'h0001, 16'h7FFF, 16'h1234);

        drive(1, 3'b011, 16'hC100, 16'h0001, 16'h7FFF, 16'h0000);
        e = m; e.dr = 16'h8000; e.s = 1; e.z = 0; e.c = 0; e.v = 1; e.w = 1; e.a = 3'd1;
        gold(e);

        drive(1, 3'b011, 16'hC050, 16'h0005, 16'h0003, 16'h0000);
        e = m; e.dr = 16'hFFFE; e.s = 1; e.z = 0; e.c = 1; e.v = 0; e.w = 0; e.a = 3'd0;
        gold(e);

        drive(1, 3'b011, 16'hC081, 16'h0000, 16'h8001, 16'h0000);
        e = m; e.dr = 16'h0002; e.c = 1; e.v = 0; e.s = 0; e.z = 0; e.w = 1;
        gold(e);
        drive(1, 3'b011, 16'hC091, 16'h0000, 16'h8001, 16'h0000);
        e = m; e.dr = 16'h0003; e.c = 1; e.v = 0; e.s = 0; e.z = 0; e.w = 1;
        gold(e);
        drive(1, 3'b011, 16'hC0B1, 16'h0000, 16'h8001, 16'h0000);
        e = m; e.dr = 16'hC000; e.c = 1; e.v = 0; e.s = 1; e.z = 0; e.w = 1;
        gold(e);
        drive(1, 3'b011, 16'hC080, 16'h0000, 16'h8001, 16'h0000);
        e = m; e.dr = 16'h8001; e.c = 0; e.v = 0; e.s = 1; e.z = 0; e.w = 1;
        gold(e);

        drive(1, 3'b011, 16'h8280, 16'h0000, 16'h0000, 16'h0000);
        e = m; e.dr = 16'hFF80; e.a = 3'd2; e.w = 1; e.s = 1; e.z = 0; e.c = 0; e.v = 0;
        gold(e);

        drive(1, 3'b011, 16'hC5C0, 16'h0000, 16'h0000, 16'hABCD);
        drive(1, 3'b011, 16'hC0D0, 16'h1234, 16'h0000, 16'h0000);
        drive(1, 3'b011, 16'h4310, 16'hFFF0, 16'h0000, 16'h0000);

        for (int k = 0; k < 4; k++)
            drive(1, 3'b101, 16'hC100, 16'h0001, 16'h7FFF, 16'h0000);

        drive(1, 3'b011, 16'hC0F0, 16'h0000, 16'h0000, 16'h0000);
        e = m; e.h = 1; e.w = 0;
        gold(e);
        drive(1, 3'b011, 16'hC100, 16'h0001, 16'h7FFF, 16'h0000);
        drive(0, 3'b011, 16'hC100, 16'h0001, 16'h7FFF, 16'h0000);
        gold('0);

        for (int k = 0; k < 600; k++) begin
            ri  = 16'($urandom);
            rop = ri[7:4];
            if (ri[15:14] == 2'b11 && rop == 4'hF && $urandom_range(0, 5) != 0)
                ri[7:4] = 4'($urandom_range(0, 14));
            if (ri[15:14] == 2'b10 && $urandom_range(0, 1) == 0)
                ri[13:11] = 3'b000;
            rr = !(($urandom_range(0, 49) == 0) || (m.h && $urandom_range(0, 4) == 0));
            rs = ($urandom_range(0, 4) != 0) ? 3'b011 : 3'($urandom);
            drive(rr, rs, ri, pick(), pick(), 16'($urandom));
        end

        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            @(negedge clock);
            #3;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/p3_execute.md
P3_EXECUTE -- requirements
Module: p3_execute

Interface
REQ-001 clock  in  1  system clock; all state updates on falling edge.
REQ-002 reset  in  1  reset, synchronous, active-low.
REQ-003 state  in  3  phase code; 3'b011 = execute phase.
REQ-004 ir  in  16  current instruction word.
REQ-005 ar  in  16  Rs / base operand from decode stage.
REQ-006 br  in  16  Rd operand from decode stage.
REQ-007 ext_in  in  16  external input port sampled by IN.
REQ-008 dr  out  16  registered result; feeds writeback data_for_write.
REQ-009 op_reg_write  out  1  registered; 1 = writeback shall store dr.
REQ-010 address_for_write  out  3  registered destination register index.
REQ-011 flag_s, flag_z, flag_c, flag_v  out  1 each  registered condition flags.
REQ-012 out_data  out  16  registered external output port.
REQ-013 halt  out  1  registered sticky halt indicator.

Function
REQ-014 Updates SHALL occur only on a falling clock edge with state==3'b011 and halt==0; otherwise all outputs hold.
REQ-015 Arithmetic class (ir[15:14]==2'b11) SHALL decode op=ir[7:4]; destination = ir[10:8]; B=br, A=ar.
REQ-016 ADD 0000: dr=B+A; C=carry out of bit 15; V=signed overflow; write=1.
REQ-017 SUB 0001: dr=B-A; C=1 iff B<A unsigned; V=signed overflow; write=1.
REQ-018 AND 0010 / OR 0011 / XOR 0100: bitwise B op A; C=0, V=0; write=1.
REQ-019 CMP 0101: flags as SUB; dr=B-A; write=0.
REQ-020 MOV 0110: dr=A; C=0, V=0; write=1.
REQ-021 Shifts, amount n=ir[3:0] (0..15), operand B: SLL 1000 logical left; SLR 1001 rotate left; SRL 1010 logical right; SRA 1011 arithmetic right; write=1.
REQ-022 Shift C = last bit shifted out (SLR: bit rotated into bit 0); n==0: dr=B, C=0; V=0 for all shifts.
REQ-023 For REQ-016..REQ-022: S=dr[15], Z=(dr==16'h0000).
REQ-024 IN 1100: dr=ext_in; write=1; flags unchanged.
REQ-025 OUT 1101: out_data=A; dr unchanged; write=0; flags unchanged.
REQ-026 HLT 1111: halt=1; write=0; flags, dr unchanged; halt sticky until reset.
REQ-027 Reserved 0111, 1110: write=0; dr, flags unchanged.
REQ-028 LI (ir[15:11]==5'b10000): dr=sign-extend(ir[7:0]); destination ir[10:8]; write=1; flags unchanged.
REQ-029 LD/ST (ir[15:14]==2'b00/2'b01): dr=A+sign-extend(ir[7:0]) (effective address, mod 2^16); write=0; flags unchanged.
REQ-030 Any other ir[15:14]==2'b10 encoding: dr=sign-extend(ir[7:0]); write=0; flags unchanged.
REQ-031 All arithmetic SHALL be 16-bit, wrap modulo 2^16; no saturation.
REQ-032 op_reg_write and address_for_write SHALL update each execute phase (address = ir[10:8] in all classes) and hold outside it.
REQ-033 Latency: one falling edge from execute-phase entry to valid dr/flags; results stable through writeback phase 3'b101.

Reset
REQ-034 reset==0 at a falling edge SHALL force dr=0, out_data=0, all flags=0, op_reg_write=0, address_for_write=0, halt=0, regardless of state or halt.
REQ-035 Reset SHALL take priority over execute-phase update in the same edge.

Verification
REQ-036 ADD: B=16'h7FFF, A=16'h0001, ir=16'hC100 -> dr=16'h8000, S=1, Z=0, C=0, V=1, write=1, addr=1.
REQ-037 SUB/CMP: B=16'h0003, A=16'h0005, op 0101 -> dr=16'hFFFE, S=1, C=1, V=0, write=0.
REQ-038 Shifts: B=16'h8001, n=1: SLL -> 16'h0002 C=1; SLR -> 16'h0003 C=1; SRA -> 16'hC000 C=1; n=0 -> 16'h8001 C=0.
REQ-039 LI ir=16'h8280 -> dr=16'hFF80, addr=2, write=1, flags unchanged from prior value.
REQ-040 HLT then execute-phase ADD -> halt=1, dr unchanged; reset=0 -> all outputs zero, halt=0.
REQ-041 state!=3'b011 with valid ADD operands -> no output changes across 4 edges.
